// File: rtl/breath_pkg.sv
// -----------------------------------------------------------------------------
// breath_pkg
// Shared definitions for the breathing-LED timebase: phase encoding, default
// parameter values and a width helper used when sizing counters.
// -----------------------------------------------------------------------------
package breath_pkg;

  // Phase encoding is visible on the phase output port, so values are fixed.
  typedef enum logic [1:0] {
    PH_RISE    = 2'd0,
    PH_HOLD_HI = 2'd1,
    PH_FALL    = 2'd2,
    PH_HOLD_LO = 2'd3
  } phase_e;

  localparam int DEF_CNT_US_MAX = 49;
  localparam int DEF_CNT_MS_MAX = 999;
  localparam int DEF_STEP_MAX   = 999;
  localparam int DEF_HOLD_STEPS = 250;

  // Width of pwm_pos, duty and the hold counter.
  localparam int POS_W = 10;

  // Bits needed to hold 0..max; a terminal count of 0 still needs one bit.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/breath_prescaler.sv
// -----------------------------------------------------------------------------
// breath_prescaler
// Generic modulo counter: counts 0..MAX while en=1 and wraps to 0. tc is the
// terminal-count strobe, decoded combinationally so it lines up with the
// cycle in which cnt sits at MAX.
//
// Ports
//   sys_clk  in   clock, rising edge
//   sys_rst  in   synchronous active-high reset
//   en       in   advance enable; also qualifies tc
//   clr      in   synchronous restart to 0
//   cnt      out  current count [W-1:0]
//   tc       out  en && cnt == MAX
// -----------------------------------------------------------------------------
module breath_prescaler #(
  parameter int W   = 6,
  parameter int MAX = 49
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign tc = en && (cnt == MAX_V);

  // NOTE: clocked state uses non-blocking assignments so every register in
  // the design samples pre-edge values regardless of process ordering.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/breath_timebase.sv
// -----------------------------------------------------------------------------
// breath_timebase
// Timebase and brightness sequencer for a breathing LED. A microsecond
// prescaler feeds a PWM-frame counter (pwm_pos); at each frame end the
// brightness (duty) steps through RISE -> HOLD_HI -> FALL -> HOLD_LO.
// A downstream stage lights the LED while pwm_pos < duty.
//
// Build option: define BREATH_HOLD_EN to include the HOLD_HI / HOLD_LO phases
// and the hold counter. Without it the sequence is a plain triangle
// RISE <-> FALL and HOLD_STEPS is only range-checked.
//
// Ports
//   sys_clk     in   clock, rising edge
//   sys_rst     in   synchronous active-high reset (highest priority)
//   run         in   1 = advance, 0 = freeze all state
//   clear       in   synchronous restart of the breath cycle, same as reset
//   tick_us     out  single-cycle prescaler strobe
//   tick_ms     out  single-cycle end-of-frame strobe
//   tick_cycle  out  single-cycle end-of-breath strobe
//   pwm_pos     out  [9:0] position within the current PWM frame
//   duty        out  [9:0] current brightness level, 0..STEP_MAX
//   phase       out  [1:0] RISE=0, HOLD_HI=1, FALL=2, HOLD_LO=3
// -----------------------------------------------------------------------------
module breath_timebase
  import breath_pkg::*;
#(
  parameter int CNT_US_MAX = DEF_CNT_US_MAX,
  parameter int CNT_MS_MAX = DEF_CNT_MS_MAX,
  parameter int STEP_MAX   = DEF_STEP_MAX,
  parameter int HOLD_STEPS = DEF_HOLD_STEPS
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             run,
  input  logic             clear,
  output logic             tick_us,
  output logic             tick_ms,
  output logic             tick_cycle,
  output logic [POS_W-1:0] pwm_pos,
  output logic [POS_W-1:0] duty,
  output logic [1:0]       phase
);

  localparam int               US_W     = cnt_width(CNT_US_MAX);
  localparam logic [POS_W-1:0] STEP_TOP = POS_W'(STEP_MAX);

  // Reject configurations outside the legal ranges at elaboration.
  if (CNT_US_MAX < 0 || CNT_MS_MAX < 1 || CNT_MS_MAX > 1023 ||
      STEP_MAX < 1 || STEP_MAX > CNT_MS_MAX ||
      HOLD_STEPS < 1 || HOLD_STEPS > 1023) begin : g_bad_params
    $error("breath_timebase: parameter outside legal range");
  end

  // Advance only when running and not being restarted, so no strobe can fire
  // in a cycle where reset or clear wipes the state.
  logic adv;
  assign adv = run && !sys_rst && !clear;

  // The sub-tick position of the prescaler is not exported.
  logic [US_W-1:0] us_cnt_unused;

  breath_prescaler #(
    .W   (US_W),
    .MAX (CNT_US_MAX)
  ) u_us_prescaler (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (adv),
    .clr     (clear),
    .cnt     (us_cnt_unused),
    .tc      (tick_us)
  );

  // Frame counter: the same modulo counter stepped by tick_us.
  breath_prescaler #(
    .W   (POS_W),
    .MAX (CNT_MS_MAX)
  ) u_frame_counter (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (tick_us),
    .clr     (clear),
    .cnt     (pwm_pos),
    .tc      (tick_ms)
  );

  // ---------------------------------------------------------------------------
  // Breath sequencer. All transitions happen only on tick_ms, which is already
  // 0 while frozen, so run needs no further handling here.
  // ---------------------------------------------------------------------------
  phase_e           phase_q, phase_d;
  logic [POS_W-1:0] duty_q, duty_d;

`ifdef BREATH_HOLD_EN
  localparam logic [POS_W-1:0] HOLD_LAST = POS_W'(HOLD_STEPS - 1);
  logic [POS_W-1:0] hold_q, hold_d;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clear) begin
      phase_q <= PH_RISE;
      duty_q  <= '0;
`ifdef BREATH_HOLD_EN
      hold_q  <= '0;
`endif
    end else begin
      phase_q <= phase_d;
      duty_q  <= duty_d;
`ifdef BREATH_HOLD_EN
      hold_q  <= hold_d;
`endif
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    phase_d    = phase_q;
    duty_d     = duty_q;
    tick_cycle = 1'b0;
`ifdef BREATH_HOLD_EN
    hold_d     = hold_q;
`endif
    if (tick_ms) begin
      case (phase_q)
        PH_RISE: begin
          if (duty_q == STEP_TOP) begin
`ifdef BREATH_HOLD_EN
            phase_d = PH_HOLD_HI;
`else
            phase_d = PH_FALL;
`endif
          end else begin
            duty_d = duty_q + POS_W'(1);
          end
        end
        PH_FALL: begin
          if (duty_q == '0) begin
`ifdef BREATH_HOLD_EN
            phase_d = PH_HOLD_LO;
`else
            phase_d    = PH_RISE;
            tick_cycle = 1'b1;
`endif
          end else begin
            duty_d = duty_q - POS_W'(1);
          end
        end
`ifdef BREATH_HOLD_EN
        PH_HOLD_HI, PH_HOLD_LO: begin
          // The counter is compared before incrementing, so each hold phase
          // lasts exactly HOLD_STEPS frames.
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (phase_q == PH_HOLD_HI) begin
              phase_d = PH_FALL;
            end else begin
              phase_d    = PH_RISE;
              tick_cycle = 1'b1;
            end
          end else begin
            hold_d = hold_q + POS_W'(1);
          end
        end
`endif
        default: begin
          phase_d = PH_RISE;
        end
      endcase
    end
  end

  assign duty  = duty_q;
  assign phase = phase_q;

endmodule

// File: tb/tb_breath_timebase.sv
// -----------------------------------------------------------------------------
// tb_breath_timebase
// Directed bench for breath_timebase with CNT_US_MAX=1, CNT_MS_MAX=3,
// STEP_MAX=3, HOLD_STEPS=2. Expected outputs come from the per-frame duty and
// phase tables of the breath sequence, indexed by cycles since release.
// Works with or without BREATH_HOLD_EN defined.
// -----------------------------------------------------------------------------
module tb_breath_timebase;

  localparam int CNT_US_MAX = 1;
  localparam int CNT_MS_MAX = 3;
  localparam int STEP_MAX   = 3;
  localparam int HOLD_STEPS = 2;

`ifdef BREATH_HOLD_EN
  localparam int FRAMES   = 12;
  localparam int K_CLEAR  = 59;  // FALL, duty 2, tick_us active
  localparam int K_RESET  = 47;  // last cycle of HOLD_HI, tick_ms active
`else
  localparam int FRAMES   = 8;
  localparam int K_CLEAR  = 43;  // FALL, duty 2, tick_us active
  localparam int K_RESET  = 31;  // RISE at peak, tick_ms active
`endif
  localparam int PERIOD = 8 * FRAMES;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       run     = 1'b0;
  logic       clear   = 1'b0;
  logic       tick_us, tick_ms, tick_cycle;
  logic [9:0] pwm_pos, duty;
  logic [1:0] phase;

  int tests_run    = 0;
  int tests_failed = 0;

  breath_timebase #(
    .CNT_US_MAX (CNT_US_MAX),
    .CNT_MS_MAX (CNT_MS_MAX),
    .STEP_MAX   (STEP_MAX),
    .HOLD_STEPS (HOLD_STEPS)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .run        (run),
    .clear      (clear),
    .tick_us    (tick_us),
    .tick_ms    (tick_ms),
    .tick_cycle (tick_cycle),
    .pwm_pos    (pwm_pos),
    .duty       (duty),
    .phase      (phase)
  );

  always #5 sys_clk = ~sys_clk;

  // Packed view: {tick_us, tick_ms, tick_cycle, pwm_pos, duty, phase}.
  logic [24:0] obs;
  assign obs = {tick_us, tick_ms, tick_cycle, pwm_pos, duty, phase};

  // Expected packed outputs k cycles after release with run=1.
  function automatic logic [24:0] model(input int k);
    int cyc, f, d, p;
    cyc = k % PERIOD;
    f   = cyc / 8;
`ifdef BREATH_HOLD_EN
    case (f)
      0, 1, 2:    d = f;
      3, 4, 5, 6: d = 3;
      7:          d = 2;
      8:          d = 1;
      default:    d = 0;
    endcase
    if (f < 4)       p = 0;
    else if (f < 6)  p = 1;
    else if (f < 10) p = 2;
    else             p = 3;
`else
    d = (f < 4) ? f : 7 - f;
    p = (f < 4) ? 0 : 2;
`endif
    return {cyc % 2 == 1, cyc % 8 == 7, cyc == PERIOD - 1,
            10'((cyc / 2) % 4), 10'(d), 2'(p)};
  endfunction

  // Leaves the DUT just out of reset with run=1, one tick after a rising edge.
  task automatic do_reset();
    sys_rst = 1'b1;
    clear   = 1'b0;
    run     = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    run     = 1'b1;
    clear   = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    tests_run++;
    if (obs !== 25'h0) begin
      tests_failed++;
      $display("FAIL reset_state got=%h want=%h", obs, 25'h0);
    end
  endtask

  task automatic test_timebase();
    logic [24:0] e;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge sys_clk);
      e = model(k);
      tests_run++;
      if ({tick_us, tick_ms, pwm_pos} !== {e[24], e[23], e[21:12]}) begin
        tests_failed++;
        $display("FAIL timebase k=%0d got us=%b ms=%b pos=%0d want us=%b ms=%b pos=%0d",
                 k, tick_us, tick_ms, pwm_pos, e[24], e[23], e[21:12]);
      end
    end
  endtask

  task automatic test_breath();
    logic [24:0] e;
    int          cycles_seen;
    int          last_tc;
    cycles_seen = 0;
    last_tc     = -1;
    do_reset();
    for (int k = 0; k < 2 * PERIOD; k++) begin
      @(negedge sys_clk);
      e = model(k);
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL breath k=%0d got=%h want=%h", k, obs, e);
      end
      if (tick_cycle === 1'b1) begin
        if (last_tc >= 0) begin
          tests_run++;
          if (k - last_tc != PERIOD) begin
            tests_failed++;
            $display("FAIL tick_cycle_spacing got=%0d want=%0d", k - last_tc, PERIOD);
          end
        end
        last_tc = k;
        cycles_seen++;
      end
    end
    tests_run++;
    if (cycles_seen != 2) begin
      tests_failed++;
      $display("FAIL tick_cycle_count got=%0d want=%0d", cycles_seen, 2);
    end
  endtask

  task automatic test_freeze();
    logic [24:0] e;
    do_reset();
    for (int k = 0; k < 20; k++) @(negedge sys_clk);
    // Now at k=19: duty 2, prescaler at terminal count.
    run = 1'b0;
    e = model(19);
    e[24:22] = 3'b000;
    for (int i = 0; i <= 20; i++) begin
      if (i == 0) #1;
      else @(negedge sys_clk);
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL freeze i=%0d got=%h want=%h", i, obs, e);
      end
    end
    run = 1'b1;
    #1;
    e = model(19);
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL freeze_resume got=%h want=%h", obs, e);
    end
    for (int k = 20; k < 40; k++) begin
      @(negedge sys_clk);
      e = model(k);
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL freeze_after k=%0d got=%h want=%h", k, obs, e);
      end
    end
  endtask

  task automatic test_clear();
    logic [24:0] e;
    do_reset();
    for (int k = 0; k <= K_CLEAR; k++) @(negedge sys_clk);
    tests_run++;
    if ({duty, phase} !== {10'd2, 2'd2}) begin
      tests_failed++;
      $display("FAIL clear_setup got duty=%0d phase=%0d want duty=2 phase=2", duty, phase);
    end
    clear = 1'b1;
    #1;
    tests_run++;
    if ({tick_us, tick_ms, tick_cycle} !== 3'b000) begin
      tests_failed++;
      $display("FAIL clear_ticks got=%b want=000", {tick_us, tick_ms, tick_cycle});
    end
    @(posedge sys_clk);
    #1 clear = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      e = model(k);
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL clear_restart k=%0d got=%h want=%h", k, obs, e);
      end
    end
  endtask

  task automatic test_reset_priority();
    logic [24:0] e;
    do_reset();
    for (int k = 0; k <= K_RESET; k++) @(negedge sys_clk);
    sys_rst = 1'b1;
    clear   = 1'b1;
    #1;
    tests_run++;
    if ({tick_us, tick_ms, tick_cycle} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ticks got=%b want=000", {tick_us, tick_ms, tick_cycle});
    end
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    clear   = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      e = model(k);
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL reset_restart k=%0d got=%h want=%h", k, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timebase();
    test_breath();
    test_freeze();
    test_clear();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
